// File: rtl/image_write.sv
// Frame buffer that captures pixel pairs, then streams a 24-bit BMP file (header + bottom-up BGR
// pixels) one byte per transfer over a valid/ready interface.
module image_write #(
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned HEIGHT = 512
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       data_write,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned HDR_BYTES  = 54;
    localparam int unsigned PIX_BYTES  = 3 * WIDTH * HEIGHT;
    localparam int unsigned FILE_BYTES = HDR_BYTES + PIX_BYTES;
    localparam int unsigned NUM_PAIRS  = WIDTH * HEIGHT / 2;

    localparam int unsigned AW = $clog2(PIX_BYTES);
    localparam int unsigned PW = $clog2(FILE_BYTES);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BW = $clog2(NUM_PAIRS + 1);

    localparam logic [31:0] FSZ = 32'(FILE_BYTES);
    localparam logic [31:0] ISZ = 32'(PIX_BYTES);
    localparam logic [31:0] WID = 32'(WIDTH);
    localparam logic [31:0] HGT = 32'(HEIGHT);

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_HEADER,
        ST_PIXELS
    } state_e;

    state_e         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           frame_done_q, frame_done_d;
    logic           overrun_q, overrun_d;

    logic [7:0]     mem [PIX_BYTES];
    logic           capture;
    logic           xfer;
    logic [AW-1:0]  wr_base;
    logic [AW-1:0]  rd_addr;

    // Little-endian BITMAPFILEHEADER + BITMAPINFOHEADER; unlisted offsets are zero.
    function automatic logic [7:0] hdr_byte(input logic [PW-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (32'(idx))
            0:       b = 8'h42;
            1:       b = 8'h4D;
            2:       b = FSZ[7:0];
            3:       b = FSZ[15:8];
            4:       b = FSZ[23:16];
            5:       b = FSZ[31:24];
            10:      b = 8'd54;
            14:      b = 8'd40;
            18:      b = WID[7:0];
            19:      b = WID[15:8];
            20:      b = WID[23:16];
            21:      b = WID[31:24];
            22:      b = HGT[7:0];
            23:      b = HGT[15:8];
            24:      b = HGT[23:16];
            25:      b = HGT[31:24];
            26:      b = 8'd1;
            28:      b = 8'd24;
            34:      b = ISZ[7:0];
            35:      b = ISZ[15:8];
            36:      b = ISZ[23:16];
            37:      b = ISZ[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign capture = (state_q == ST_CAPTURE) && data_write;
    assign xfer    = out_valid && out_ready;

    // Input row 0 lands in the last file row (BMP rows are stored bottom-up).
    always_comb begin
        wr_base = AW'(3 * (WIDTH * (HEIGHT - 1 - 32'(row_q)) + 32'(col_q)));
        rd_addr = AW'(32'(ptr_q) - HDR_BYTES);
    end

    always_ff @(posedge HCLK) begin
        if (capture) begin
            mem[wr_base]          <= DATA_B0;
            mem[wr_base + AW'(1)] <= DATA_G0;
            mem[wr_base + AW'(2)] <= DATA_R0;
            mem[wr_base + AW'(3)] <= DATA_B1;
            mem[wr_base + AW'(4)] <= DATA_G1;
            mem[wr_base + AW'(5)] <= DATA_R1;
        end
    end

    always_comb begin
        out_valid = (state_q != ST_CAPTURE);
        out_data  = 8'h00;
        out_last  = 1'b0;
        if (state_q == ST_HEADER) begin
            out_data = hdr_byte(ptr_q);
        end else if (state_q == ST_PIXELS) begin
            out_data = mem[rd_addr];
            out_last = (ptr_q == PW'(FILE_BYTES - 1));
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        beat_d       = beat_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (data_write && (state_q != ST_CAPTURE));

        case (state_q)
            ST_CAPTURE: begin
                if (data_write) begin
                    if (beat_q == BW'(NUM_PAIRS - 1)) begin
                        state_d = ST_HEADER;
                        beat_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        if (col_q == CW'(WIDTH - 2)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(2);
                        end
                    end
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    ptr_d = ptr_q + PW'(1);
                    if (ptr_q == PW'(HDR_BYTES - 1)) begin
                        state_d = ST_PIXELS;
                    end
                end
            end
            ST_PIXELS: begin
                if (xfer) begin
                    if (out_last) begin
                        state_d      = ST_CAPTURE;
                        ptr_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_CAPTURE;
            row_q        <= '0;
            col_q        <= '0;
            beat_q       <= '0;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            beat_q       <= beat_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_image_write.sv
// Scoreboard bench for image_write at WIDTH=4, HEIGHT=2: expected BMP bytes are queued from a
// reference model when a frame is driven and popped as the DUT transfers bytes.
module tb_image_write;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned NB = 54 + 3 * W * H;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       data_write = 1'b0;
    logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       overrun;

    image_write #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .data_write (data_write),
        .DATA_R0    (DATA_R0),
        .DATA_G0    (DATA_G0),
        .DATA_B0    (DATA_B0),
        .DATA_R1    (DATA_R1),
        .DATA_G1    (DATA_G1),
        .DATA_B1    (DATA_B1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rx[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         rand_ready = 1'b0;

    int   first_xfer_cyc, last_xfer_cyc, first_valid_cyc, last_beat_cyc;
    int   fd_cyc = -1, fd_cnt = 0, fd_overlap = 0;
    logic prev_stall = 1'b0, prev_last = 1'b0, prev_valid = 1'b0;
    logic [7:0] prev_data = '0;
    exp_t e;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(posedge HCLK) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard consumer and stall-stability monitor.
    always @(negedge HCLK) begin
        if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
                $display("FAIL stall_hold: got valid=%b data=%h last=%b, required 1/%h/%b",
                         out_valid, out_data, out_last, prev_data, prev_last);
            else n_pass++;
        end
        if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_byte: got data=%h last=%b, required no transfer",
                         out_data, out_last);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_last !== e.last)
                    $display("FAIL file_byte[%0d]: got %h last=%b, required %h last=%b",
                             rx.size(), out_data, out_last, e.data, e.last);
                else n_pass++;
            end
            if (rx.size() == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            rx.push_back(out_data);
        end
        if (out_valid && !prev_valid) first_valid_cyc = cyc;
        if (data_write && !out_valid) last_beat_cyc = cyc;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            if (data_write) fd_overlap++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_valid = out_valid;
    end

    function automatic logic [7:0] pix(input int r, input int c, input int ch, input bit inv);
        logic [7:0] v, p;
        v = 8'(16 * r + c);
        case (ch)
            0:       p = v;
            1:       p = 8'h40 + v;
            default: p = 8'h80 + v;
        endcase
        return inv ? ~p : p;
    endfunction

    task automatic push_expected(input bit inv);
        logic [7:0] h [54];
        int   fsz, isz, r;
        exp_t x;
        fsz = 54 + 3 * W * H;
        isz = 3 * W * H;
        foreach (h[i]) h[i] = 8'h00;
        h[0] = 8'h42;
        h[1] = 8'h4D;
        for (int k = 0; k < 4; k++) begin
            h[2 + k]  = 8'(fsz >> (8 * k));
            h[18 + k] = 8'(W >> (8 * k));
            h[22 + k] = 8'(H >> (8 * k));
            h[34 + k] = 8'(isz >> (8 * k));
        end
        h[10] = 8'd54;
        h[14] = 8'd40;
        h[26] = 8'd1;
        h[28] = 8'd24;
        for (int i = 0; i < 54; i++) begin
            x.data = h[i];
            x.last = 1'b0;
            sb.push_back(x);
        end
        for (int fr = 0; fr < int'(H); fr++) begin
            r = int'(H) - 1 - fr;
            for (int c = 0; c < int'(W); c++) begin
                for (int ch = 2; ch >= 0; ch--) begin
                    x.data = pix(r, c, ch, inv);
                    x.last = (fr == int'(H) - 1) && (c == int'(W) - 1) && (ch == 0);
                    sb.push_back(x);
                end
            end
        end
    endtask

    task automatic drive_pairs(input int npairs, input bit inv, input int max_gap);
        int r, c, g;
        for (int p = 0; p < npairs; p++) begin
            r = p / (int'(W) / 2);
            c = 2 * (p % (int'(W) / 2));
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                @(posedge HCLK); #1;
                data_write = 1'b0;
            end
            @(posedge HCLK); #1;
            data_write = 1'b1;
            DATA_R0 = pix(r, c, 0, inv);
            DATA_G0 = pix(r, c, 1, inv);
            DATA_B0 = pix(r, c, 2, inv);
            DATA_R1 = pix(r, c + 1, 0, inv);
            DATA_G1 = pix(r, c + 1, 1, inv);
            DATA_B1 = pix(r, c + 1, 2, inv);
        end
        @(posedge HCLK); #1;
        data_write = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int budget = 2000;
        while ((sb.size() != 0 || out_valid) && budget > 0) begin
            @(negedge HCLK); #1;
            budget--;
        end
        n_checks++;
        if (budget == 0)
            $display("FAIL %s_timeout: got %0d bytes outstanding, required 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h, required 00", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b, required 0", out_last); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b, required 0", frame_done); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b, required 0", overrun); else n_pass++;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    task automatic test_basic();
        int fd0 = fd_cnt;
        rx.delete();
        push_expected(1'b0);
        drive_pairs(4, 1'b0, 0);
        wait_frame("basic");
        n_checks++; if (rx.size() != NB) $display("FAIL basic_count: got %0d, required %0d", rx.size(), NB); else n_pass++;
        n_checks++;
        if (last_xfer_cyc - first_xfer_cyc != int'(NB) - 1)
            $display("FAIL basic_span: got %0d cycles, required %0d", last_xfer_cyc - first_xfer_cyc, NB - 1);
        else n_pass++;
        n_checks++;
        if (first_valid_cyc != last_beat_cyc + 1)
            $display("FAIL basic_hdr_latency: got %0d, required %0d", first_valid_cyc, last_beat_cyc + 1);
        else n_pass++;
        if (rx.size() == NB) begin
            n_checks++;
            if ({rx[2], rx[3], rx[4], rx[5]} !== 32'h4E00_0000)
                $display("FAIL basic_fsize: got %h%h%h%h, required 4e000000", rx[2], rx[3], rx[4], rx[5]);
            else n_pass++;
            n_checks++; if (rx[18] !== 8'h04) $display("FAIL basic_width: got %h, required 04", rx[18]); else n_pass++;
            n_checks++; if (rx[22] !== 8'h02) $display("FAIL basic_height: got %h, required 02", rx[22]); else n_pass++;
            n_checks++;
            if ({rx[54], rx[55], rx[56]} !== 24'h905010)
                $display("FAIL basic_pix10: got %h%h%h, required 905010", rx[54], rx[55], rx[56]);
            else n_pass++;
        end
        n_checks++; if (fd_cnt != fd0 + 1) $display("FAIL basic_done_cnt: got %0d, required %0d", fd_cnt - fd0, 1); else n_pass++;
        n_checks++; if (fd_cyc != last_xfer_cyc + 1) $display("FAIL basic_done_cyc: got %0d, required %0d", fd_cyc, last_xfer_cyc + 1); else n_pass++;
    endtask

    task automatic test_stall();
        int fd0 = fd_cnt;
        rx.delete();
        rand_ready = 1'b1;
        push_expected(1'b0);
        drive_pairs(4, 1'b0, 0);
        wait_frame("stall");
        rand_ready = 1'b0;
        n_checks++; if (rx.size() != NB) $display("FAIL stall_count: got %0d, required %0d", rx.size(), NB); else n_pass++;
        n_checks++; if (fd_cnt != fd0 + 1) $display("FAIL stall_done_cnt: got %0d, required 1", fd_cnt - fd0); else n_pass++;
    endtask

    task automatic test_gaps();
        rx.delete();
        push_expected(1'b0);
        drive_pairs(4, 1'b0, 5);
        wait_frame("gaps");
        n_checks++; if (rx.size() != NB) $display("FAIL gaps_count: got %0d, required %0d", rx.size(), NB); else n_pass++;
    endtask

    task automatic test_overrun();
        rx.delete();
        push_expected(1'b0);
        drive_pairs(4, 1'b0, 0);
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_before: got %b, required 0", overrun); else n_pass++;
        data_write = 1'b1;
        {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = '1;
        @(posedge HCLK); #1;
        data_write = 1'b0;
        @(negedge HCLK);
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b, required 1", overrun); else n_pass++;
        wait_frame("overrun");
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b, required 1", overrun); else n_pass++;
        n_checks++; if (rx.size() != NB) $display("FAIL ovr_count: got %0d, required %0d", rx.size(), NB); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rx.delete();
        drive_pairs(2, 1'b1, 0);
        HRESET = 1'b1;
        #1;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rmid_async: got overrun=%b, required 0", overrun); else n_pass++;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        push_expected(1'b0);
        drive_pairs(4, 1'b0, 0);
        wait_frame("reset_mid");
        n_checks++; if (rx.size() != NB) $display("FAIL rmid_count: got %0d, required %0d", rx.size(), NB); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rmid_overrun: got %b, required 0", overrun); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int fd0 = fd_cnt;
        int ov0 = fd_overlap;
        int budget = 2000;
        rx.delete();
        push_expected(1'b0);
        drive_pairs(4, 1'b0, 0);
        while (!(out_valid && out_ready && out_last) && budget > 0) begin
            @(negedge HCLK); #1;
            budget--;
        end
        n_checks++;
        if (budget == 0) $display("FAIL b2b_last_timeout: got no out_last, required one");
        else n_pass++;
        push_expected(1'b1);
        drive_pairs(4, 1'b1, 0);
        wait_frame("b2b");
        n_checks++; if (rx.size() != 2 * NB) $display("FAIL b2b_count: got %0d, required %0d", rx.size(), 2 * NB); else n_pass++;
        n_checks++; if (fd_cnt != fd0 + 2) $display("FAIL b2b_done_cnt: got %0d, required 2", fd_cnt - fd0); else n_pass++;
        n_checks++; if (fd_overlap != ov0 + 1) $display("FAIL b2b_overlap: got %0d, required 1", fd_overlap - ov0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gaps();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(posedge HCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
